// File: rtl/nibble_add_sequencer.sv
// W-bit add/subtract built by time-sharing one external 4-bit adder, one nibble
// per cycle starting with the LSB nibble. The carry is chained through a register.
module nibble_add_sequencer #(
  parameter  int NIBBLES = 4,
  localparam int W       = 4 * NIBBLES,
  localparam int IW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         ovf,
  output logic [3:0]   add_a,
  output logic [3:0]   add_b,
  output logic         add_cin,
  input  logic [3:0]   add_s,
  input  logic         add_cout,
  input  logic         add_v
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] idx_q,   idx_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  a_q,     a_d;
  logic [W-1:0]  b_q,     b_d;
  logic [W-1:0]  result_q, result_d;
  logic          cout_q,  cout_d;
  logic          ovf_q,   ovf_d;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    add_a    = 4'd0;
    add_b    = 4'd0;
    add_cin  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Subtract is a + ~b + 1: invert b here and seed the carry with 1.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        add_a   = a_q[{idx_q, 2'b00} +: 4];
        add_b   = b_q[{idx_q, 2'b00} +: 4];
        add_cin = carry_q;
        result_d[{idx_q, 2'b00} +: 4] = add_s;
        carry_d = add_cout;
        idx_d   = idx_q + IW'(1);
        if (idx_q == LAST_IDX) begin
          cout_d  = add_cout;
          ovf_d   = add_v;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; next-state values come from the comb block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign ready  = (state_q == S_IDLE);
  assign busy   = (state_q == S_RUN) || (state_q == S_DONE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_nibble_add_sequencer.sv
// Randomized bench for nibble_add_sequencer. It models the shared four_adder and
// checks the DUT every cycle against a plain-arithmetic reference.
module tb_nibble_add_sequencer;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, sub;
  logic [W-1:0] a, b;
  logic         ready, busy, done, cout, ovf;
  logic [W-1:0] result;
  logic [3:0]   add_a, add_b, add_s;
  logic         add_cin, add_cout, add_v;

  int total = 0;
  int bad   = 0;

  nibble_add_sequencer #(.NIBBLES(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .ready(ready), .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout), .add_v(add_v)
  );

  always #5 clk = ~clk;

  // Shared four_adder: plain 4-bit add with signed overflow.
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};
  assign add_v = (add_a[3] == add_b[3]) && (add_s[3] != add_a[3]);

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: {ovf, cout, result} from whole-word arithmetic.
  function automatic logic [W+1:0] ref_op(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    longint ux, uy, r, sx, sy, sr;
    logic [63:0] rv;
    logic c, v;
    ux = x;
    uy = y;
    sx = $signed(x);
    sy = $signed(y);
    r  = s ? ux - uy : ux + uy;
    sr = s ? sx - sy : sx + sy;
    rv = r;
    c  = s ? (ux >= uy) : (r >= (64'd1 << W));
    v  = (sr > (64'sd1 <<< (W - 1)) - 1) || (sr < -(64'sd1 <<< (W - 1)));
    return {v, c, rv[W-1:0]};
  endfunction

  // Model: cycles remaining of the current operation (N+1 at RUN start, 1 in DONE, 0 idle).
  int           m_cnt;
  logic [W-1:0] m_x, m_y, m_res;
  logic         m_sub, m_cout, m_ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0; m_res = '0; m_cout = 1'b0; m_ovf = 1'b0;
      m_x = '0; m_y = '0; m_sub = 1'b0;
    end else if (m_cnt == 0) begin
      if (start) begin
        m_x = a; m_y = b; m_sub = sub; m_cnt = N + 1;
      end
    end else begin
      m_cnt--;
      if (m_cnt == 1) {m_ovf, m_cout, m_res} = ref_op(m_sub, m_x, m_y);
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    int k;
    longint mask, yeff, cin_exp;
    check("ready", ready, m_cnt == 0);
    check("busy",  busy,  m_cnt != 0);
    check("done",  done,  m_cnt == 1);
    if (m_cnt >= 2) begin
      k    = N + 1 - m_cnt;
      yeff = m_sub ? longint'(~m_y) : longint'(m_y);
      mask = (64'd1 << (4 * k)) - 1;
      cin_exp = (k == 0) ? longint'(m_sub)
              : (((longint'(m_x) & mask) + (yeff & mask) + longint'(m_sub)) >> (4 * k));
      check("add_a",   add_a,   (longint'(m_x) >> (4 * k)) & 15);
      check("add_b",   add_b,   (yeff >> (4 * k)) & 15);
      check("add_cin", add_cin, cin_exp);
    end else begin
      check("add_a_idle",   add_a,   0);
      check("add_b_idle",   add_b,   0);
      check("add_cin_idle", add_cin, 0);
      check("result", result, m_res);
      check("cout",   cout,   m_cout);
      check("ovf",    ovf,    m_ovf);
    end
  end

  task automatic wait_ready(input string tag);
    int t = 0;
    while (!ready && t < 20) begin @(negedge clk); t++; end
    check({tag, "_ready_timeout"}, ready, 1);
  endtask

  task automatic do_op(input string tag, input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] er, input logic ec, input logic ev);
    int lat = 0;
    wait_ready(tag);
    start = 1'b1; sub = s; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; sub = $urandom;
    do begin @(negedge clk); lat++; end while (!done && lat < 20);
    check({tag, "_latency"}, lat, N + 1);
    check({tag, "_result"},  result, er);
    check({tag, "_cout"},    cout, ec);
    check({tag, "_ovf"},     ovf, ev);
  endtask

  initial begin
    logic [W+1:0] e;
    logic [W-1:0] x, y;
    logic         s;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready",  ready, 1);
    check("rst_busy",   busy, 0);
    check("rst_done",   done, 0);
    check("rst_result", result, 16'h0000);
    check("rst_add_a",  add_a, 0);

    do_op("add_chain", 1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0);
    do_op("add_ovf",   1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);
    do_op("add_wrap",  1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
    do_op("sub_neg",   1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0);
    do_op("sub_ovf",   1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1);

    // start pulsed with fresh operands through RUN and DONE must be ignored.
    wait_ready("ign");
    start = 1'b1; sub = 1'b0; a = 16'h1234; b = 16'h0FFF;
    @(posedge clk); #1;
    for (int k = 1; k <= N + 1; k++) begin
      @(negedge clk);
      check("ign_done", done, k == N + 1);
      start = 1'b1; a = $urandom; b = $urandom; sub = $urandom;
    end
    @(negedge clk);
    start = 1'b0;
    check("ign_ready",  ready, 1);
    check("ign_result", result, 16'h2233);
    check("ign_cout",   cout, 0);

    // Asynchronous reset in RUN cycle 2 aborts at once.
    do_op("pre_rst", 1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0);
    wait_ready("arst");
    start = 1'b1; sub = 1'b0; a = 16'h1111; b = 16'h2222;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_ready",  ready, 1);
    check("arst_busy",   busy, 0);
    check("arst_done",   done, 0);
    check("arst_result", result, 16'h0000);
    check("arst_add_a",  add_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < N + 3; k++) begin
      @(negedge clk);
      check("arst_no_done", done, 0);
    end
    check("arst_ready_after", ready, 1);

    for (int i = 0; i < 40; i++) begin
      x = $urandom; y = $urandom; s = $urandom;
      if (i % 8 == 0) y = x;
      e = ref_op(s, x, y);
      do_op("rand", s, x, y, e[W-1:0], e[W], e[W+1]);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
